// File: rtl/forward_sel_pipe_pkg.sv
// rtl/forward_sel_pipe_pkg.sv - shared widths, forwarding select encoding and stage records
package forward_sel_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // EX operand mux select; 2'b11 is never produced
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dst;
    logic                  regwrite;
    logic                  memread;
  } ex_stage_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic                  regwrite;
    logic                  memread;
  } mem_stage_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic                  regwrite;
  } wb_stage_t;

endpackage

// File: rtl/forward_sel_pipe_if.sv
// rtl/forward_sel_pipe_if.sv - ID-stage inputs and EX forwarding/stall outputs
interface forward_sel_pipe_if;
  import forward_sel_pipe_pkg::*;

  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs_i;
  logic [REG_ADDR_W-1:0] id_rt_i;
  logic [REG_ADDR_W-1:0] id_dst_i;
  logic                  id_regwrite_i;
  logic                  id_memread_i;
  logic                  flush_i;
  logic [1:0]            fwd_a_o;
  logic [1:0]            fwd_b_o;
  logic                  stall_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_dst_i, id_regwrite_i, id_memread_i, flush_i,
    input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_dst_i, id_regwrite_i, id_memread_i, flush_i,
    output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
  );

endinterface

// File: rtl/forward_sel_pipe_fwd_compare.sv
// rtl/forward_sel_pipe_fwd_compare.sv - MEM/WB priority forwarding compare for one EX operand
module forward_sel_pipe_fwd_compare
  import forward_sel_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic                  wb_regwrite,
  output fwd_sel_e              sel
);

  // A load in MEM has no data yet, so it can only forward once it reaches WB
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && !mem_memread && (mem_dst != REG_ZERO) && (mem_dst == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_regwrite && (wb_dst != REG_ZERO) && (wb_dst == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forward_sel_pipe.sv
// rtl/forward_sel_pipe.sv - EX/MEM/WB destination tracking, operand forwarding selects and load-use stall
module forward_sel_pipe
  import forward_sel_pipe_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  forward_sel_pipe_if.slave  bus
);

  ex_stage_t        ex_q;
  mem_stage_t       mem_q;
  wb_stage_t        wb_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             stall;
  logic             bubble;
  fwd_sel_e         fwd_a;
  fwd_sel_e         fwd_b;

  // Flush suppresses the stall: the dependent instruction is being killed anyway
  assign stall = bus.id_valid_i && !bus.flush_i && ex_q.memread && (ex_q.dst != REG_ZERO) &&
                 ((ex_q.dst == bus.id_rs_i) || (ex_q.dst == bus.id_rt_i));
  assign bubble = stall || bus.flush_i || !bus.id_valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_q  <= '{dst: mem_q.dst, regwrite: mem_q.regwrite};
      mem_q <= '{dst: ex_q.dst, regwrite: ex_q.regwrite, memread: ex_q.memread};
      if (bubble) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{rs:       bus.id_rs_i,
                  rt:       bus.id_rt_i,
                  dst:      bus.id_dst_i,
                  regwrite: bus.id_regwrite_i,
                  memread:  bus.id_memread_i};
      end
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  forward_sel_pipe_fwd_compare u_cmp_a (
    .src          (ex_q.rs),
    .mem_dst      (mem_q.dst),
    .mem_regwrite (mem_q.regwrite),
    .mem_memread  (mem_q.memread),
    .wb_dst       (wb_q.dst),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (fwd_a)
  );

  forward_sel_pipe_fwd_compare u_cmp_b (
    .src          (ex_q.rt),
    .mem_dst      (mem_q.dst),
    .mem_regwrite (mem_q.regwrite),
    .mem_memread  (mem_q.memread),
    .wb_dst       (wb_q.dst),
    .wb_regwrite  (wb_q.regwrite),
    .sel          (fwd_b)
  );

  assign bus.fwd_a_o     = fwd_a;
  assign bus.fwd_b_o     = fwd_b;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_sel_pipe.sv
// tb/tb_forward_sel_pipe.sv - directed instruction stream with queued expected outputs
module tb_forward_sel_pipe;
  import forward_sel_pipe_pkg::*;

  typedef struct {
    string name;
    bit    valid;
    int    rs, rt, dst;
    bit    rw, mr, fl, rn;
    int    ea, eb, es, ec;
  } vec_t;

  typedef struct {
    string name;
    int    ea, eb, es, ec;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t stim_q[$];
  exp_t exp_q[$];

  forward_sel_pipe_if bus ();

  forward_sel_pipe dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic vec(input string name, input bit valid, input int rs, input int rt, input int dst,
                     input bit rw, input bit mr, input bit fl, input bit rn,
                     input int ea, input int eb, input int es, input int ec);
    vec_t v;
    v.name = name; v.valid = valid; v.rs = rs; v.rt = rt; v.dst = dst;
    v.rw = rw; v.mr = mr; v.fl = fl; v.rn = rn;
    v.ea = ea; v.eb = eb; v.es = es; v.ec = ec;
    stim_q.push_back(v);
  endtask

  task automatic nop(input string name, input int ea, input int eb, input int ec);
    vec(name, 0, 0, 0, 0, 0, 0, 0, 1, ea, eb, 0, ec);
  endtask

  task automatic check(input string what, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", name, what, act, req);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_a",     e.name, int'(bus.fwd_a_o),     e.ea);
        check("fwd_b",     e.name, int'(bus.fwd_b_o),     e.eb);
        check("stall",     e.name, int'(bus.stall_o),     e.es);
        check("stall_cnt", e.name, int'(bus.stall_cnt_o), e.ec);
      end
    end
  end

  initial begin
    vec_t v;
    exp_t e;
    int   wait_cyc;

    bus.id_valid_i = 0; bus.id_rs_i = '0; bus.id_rt_i = '0; bus.id_dst_i = '0;
    bus.id_regwrite_i = 0; bus.id_memread_i = 0; bus.flush_i = 0;

    // name           v  rs rt dst rw mr fl rn   a  b  s  cnt
    vec("rst_a",      1, 3, 4, 5,  1, 1, 0, 0,   0, 0, 0, 0);
    vec("rst_b",      1, 3, 3, 3,  1, 1, 0, 0,   0, 0, 0, 0);
    nop("nop0", 0, 0, 0);
    nop("nop1", 0, 0, 0);
    vec("add3",       1, 1, 2, 3,  1, 0, 0, 1,   0, 0, 0, 0);
    vec("sub5",       1, 3, 4, 5,  1, 0, 0, 1,   0, 0, 0, 0);
    nop("exmem_fwd", 1, 0, 0);
    nop("nop2", 0, 0, 0);
    vec("add3_b",     1, 1, 2, 3,  1, 0, 0, 1,   0, 0, 0, 0);
    nop("gap", 0, 0, 0);
    vec("or6",        1, 7, 3, 6,  1, 0, 0, 1,   0, 0, 0, 0);
    nop("memwb_fwd", 0, 2, 0);
    vec("add3_c",     1, 1, 2, 3,  1, 0, 0, 1,   0, 0, 0, 0);
    vec("add3_d",     1, 4, 5, 3,  1, 0, 0, 1,   0, 0, 0, 0);
    vec("and8",       1, 3, 3, 8,  1, 0, 0, 1,   0, 0, 0, 0);
    nop("prio_fwd", 1, 1, 0);
    nop("nop3", 0, 0, 0);
    nop("nop4", 0, 0, 0);
    vec("lw4",        1, 1, 4, 4,  1, 1, 0, 1,   0, 0, 0, 0);
    vec("use_stall",  1, 2, 4, 5,  1, 0, 0, 1,   0, 0, 1, 0);
    vec("use_held",   1, 2, 4, 5,  1, 0, 0, 1,   0, 0, 0, 1);
    nop("load_fwd", 0, 2, 1);
    nop("nop5", 0, 0, 1);
    vec("add0",       1, 1, 2, 0,  1, 0, 0, 1,   0, 0, 0, 1);
    vec("use0",       1, 0, 0, 5,  1, 0, 0, 1,   0, 0, 0, 1);
    nop("zero_nofwd", 0, 0, 1);
    vec("lw0",        1, 1, 0, 0,  1, 1, 0, 1,   0, 0, 0, 1);
    vec("lw0_use",    1, 0, 1, 5,  1, 0, 0, 1,   0, 0, 0, 1);
    nop("nop6", 0, 0, 1);
    nop("nop7", 0, 0, 1);
    vec("lw4_f",      1, 1, 4, 4,  1, 1, 0, 1,   0, 0, 0, 1);
    vec("flush_use",  1, 4, 2, 5,  1, 0, 1, 1,   0, 0, 0, 1);
    nop("flush_bub1", 0, 0, 1);
    nop("flush_bub2", 0, 0, 1);
    vec("add3_r",     1, 1, 2, 3,  1, 0, 0, 1,   0, 0, 0, 1);
    vec("lw7",        1, 3, 7, 7,  1, 1, 0, 1,   0, 0, 0, 1);
    vec("stall_fwd",  1, 7, 3, 9,  1, 0, 0, 1,   1, 0, 1, 1);
    vec("mid_rst",    1, 7, 3, 9,  1, 0, 0, 0,   0, 0, 0, 0);
    vec("post_rst",   1, 7, 3, 9,  1, 0, 0, 1,   0, 0, 0, 0);
    nop("empty_pipe", 0, 0, 0);

    while (stim_q.size() > 0) begin
      v = stim_q.pop_front();
      @(posedge clk_i);
      #1;
      rst_i             = v.rn;
      bus.id_valid_i    = v.valid;
      bus.id_rs_i       = REG_ADDR_W'(v.rs);
      bus.id_rt_i       = REG_ADDR_W'(v.rt);
      bus.id_dst_i      = REG_ADDR_W'(v.dst);
      bus.id_regwrite_i = v.rw;
      bus.id_memread_i  = v.mr;
      bus.flush_i       = v.fl;
      e.name = v.name; e.ea = v.ea; e.eb = v.eb; e.es = v.es; e.ec = v.ec;
      exp_q.push_back(e);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk_i);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forward_sel_pipe.md
# forward_sel_pipe

Forwarding and load-use hazard control for the 5-stage pipelined CPU. It tracks destination-register and write-enable information for instructions in EX, MEM and WB. From that state it drives the 2-bit select inputs of the two ALU-operand 3-to-1 forwarding muxes in EX, and raises a stall request on load-use hazards. It sits between ID decode and the EX-stage operand muxes.

## Interface
- REG_ADDR_W, 5, register address width
- CNT_W, 16, stall counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i  in  REG_ADDR_W  ID source register rs
- id_rt_i  in  REG_ADDR_W  ID source register rt
- id_dst_i  in  REG_ADDR_W  ID destination register (RegDst already applied)
- id_regwrite_i  in  1  ID instruction writes register file
- id_memread_i  in  1  ID instruction is a load
- flush_i  in  1  kill ID instruction this cycle (taken branch)
- fwd_a_o  out  2  operand A select: 00 register file, 01 EX/MEM result, 10 MEM/WB result
- fwd_b_o  out  2  operand B select, same encoding
- stall_o  out  1  hold PC and IF/ID, bubble into EX
- stall_cnt_o  out  CNT_W  count of stall cycles, saturating

## Operation
- Tracking registers:
  - EX: rs, rt, dst, regwrite, memread
  - MEM: dst, regwrite, memread
  - WB: dst, regwrite
- Every rising edge: WB <= MEM, MEM <= EX, EX <= ID fields.
- Bubble rule: when stall_o, flush_i or !id_valid_i, EX instead loads rs=rt=dst=0, regwrite=0, memread=0.
- Forward A, in priority order:
  - 01 if mem_regwrite && !mem_memread && mem_dst!=0 && mem_dst==ex_rs
  - else 10 if wb_regwrite && wb_dst!=0 && wb_dst==ex_rs
  - else 00
- Forward B: same rule using ex_rt.
- MEM beats WB when both match (newest value wins).
- 11 is never driven.
- Register 0 never forwards.
- stall_o = id_valid_i && !flush_i && ex_memread && ex_dst!=0 && (ex_dst==id_rs_i || ex_dst==id_rt_i).
- After one stall, the load is in MEM and a bubble is in EX. The next edge moves the consumer into EX with the load in WB, and the consumer takes 10. A load in MEM is never a 01 source.
- stall_cnt_o increments each cycle stall_o=1 and saturates at all-ones.
- flush_i and stall_o together: flush wins, stall_o=0, bubble inserted.

## Timing
- Reset (rst_i=0, async): all tracking registers 0, fwd_a_o=fwd_b_o=00, stall_o=0, stall_cnt_o=0.
- Reset mid-operation clears all in-flight tracking immediately; the first cycle after release behaves as an empty pipe.
- fwd_a_o/fwd_b_o are combinational from registered state. They are valid in the same cycle the instruction occupies EX, with no added latency.
- stall_o is combinational from ID inputs and EX registers, valid in the same cycle. Each load-use pair costs exactly one stall cycle.
- Back-to-back dependent non-load instructions cause no stall.

## Structure
- Shared package: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, REG_ZERO, REG_ADDR_W. The EX operand mux select encoding is taken from here.
- Sub-module fwd_compare: combinational MEM/WB priority compare for one operand, instanced twice (rs, rt).
- The tracking registers and stall counter live in the top module.

## Test plan
- Reset: hold rst_i=0, drive random ID inputs -> outputs 00/00/0/0. Release, run a NOP stream -> outputs stay 00, stall_cnt_o=0.
- EX/MEM forward: add $3,$1,$2 then sub $5,$3,$4 -> in the cycle sub is in EX, fwd_a_o=01, fwd_b_o=00, stall_o never 1.
- MEM/WB forward and priority:
  - add $3 / nop / or $6,$7,$3 -> fwd_b_o=10.
  - add $3 / add $3 / and $8,$3,$3 -> both selects 01.
- Load-use: lw $4,0($1) then add $5,$2,$4 -> stall_o=1 for exactly one cycle, then fwd_b_o=10 when add is in EX, stall_cnt_o=1.
- Register zero: add $0,$1,$2 then add $5,$0,$0 -> selects stay 00. lw $0 then a consumer of $0 -> no stall.
- Flush and mid-run reset:
  - lw $4 with dependent in ID plus flush_i=1 -> stall_o=0, bubble, no forward afterwards.
  - Assert rst_i mid-stream -> outputs 00/0/0 immediately.
